trinity_genome_breeder: RTL and testbench
=========================================

Name: trinity_genome_breeder

Overview:
Parametrised ternary genetic operator; next generation of the hardware-genetics path. Accepts two parent genomes of N_TRITS balanced-ternary weights through a valid/ready handshake. Breeds LANES trits per cycle, applying crossover (uniform or single-point), per-trit mutation against a runtime threshold, and canonicalisation of illegal codes. Returns the child plus a mutation count through a second valid/ready handshake. Sits between the fitness evaluator/selector and the weight store.

Parameters:
N_TRITS, 32, genome length in trits; power of two, at least 2.
LANES, 4, trits processed per BREED cycle; power of two, divides N_TRITS.
XOVER_MODE, 0, 0 = uniform per-trit crossover, 1 = single-point crossover.
LFSR_SEED, 32'hACE1, LFSR reset value; also replaces an all-zero loaded seed.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  parent pair and mut_thresh are valid.
in_ready  out  1  block can accept; high only in IDLE.
parent_a  in  2*N_TRITS  parent A, trit i at [2i+:2].
parent_b  in  2*N_TRITS  parent B.
mut_thresh  in  8  mutation probability x256, sampled on accept.
seed_load  in  1  load seed into the LFSR; honoured in IDLE only.
seed  in  32  LFSR seed value.
out_valid  out  1  child and mut_count are valid.
out_ready  in  1  consumer accepts the child.
child  out  2*N_TRITS  bred genome.
mut_count  out  $clog2(N_TRITS+1)  number of trits mutated in this child.
busy  out  1  high in BREED or DONE.

Behaviour:
- Trit encoding: 00 = -1, 01 = 0, 10 = +1. Code 11 is illegal and is always emitted as 01.
- Reset (asynchronous assert): FSM enters IDLE, lfsr = LFSR_SEED, child = 0, mut_count = 0, out_valid = 0, busy = 0, in_ready = 1. Reset mid-BREED or mid-DONE discards the job; no partial child is delivered.
- LFSR update: lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}. It advances exactly once per BREED cycle and holds otherwise.
- seed_load in IDLE: lfsr <= (seed == 0) ? LFSR_SEED : seed. If seed_load and in_valid are both high in the same IDLE cycle, the seed loads first and the job is accepted in that same cycle. In that case the cut point is taken from the new seed.
- IDLE: when in_valid && in_ready, capture parent_a, parent_b and mut_thresh, clear mut_count, set beat = 0, and go to BREED.
- IDLE, XOVER_MODE = 1: also capture cut = lfsr[$clog2(N_TRITS)-1:0]. This uses the lfsr value after any same-cycle seed load.
- BREED: each cycle handles trits j = beat*LANES + k, for k = 0..LANES-1. Let R be the current lfsr and x = R rotated right by (7*k) mod 32.
  - Crossover: pick A if x[8] (uniform mode) or if j < cut (single-point mode); otherwise pick B.
  - Mutation: if x[7:0] < mut_thresh, the trit becomes x[10:9] with 11 mapped to 01, and mut_count increments by 1. A mutation whose value equals the crossover result still counts.
  - Canonicalise the result (11 -> 01) and write it to child[2j+:2].
  - beat increments each cycle. After beat N_TRITS/LANES-1 completes, go to DONE.
- DONE: out_valid = 1. child and mut_count are stable until the cycle where out_valid && out_ready, then return to IDLE.
- Latency: accept edge -> out_valid high after exactly N_TRITS/LANES + 1 edges. There is no back-to-back overlap; in_ready is low during BREED and DONE.
- mut_thresh = 0 disables mutation. mut_thresh = 255 mutates a trit unless x[7:0] = 255.
- child holds its last value in IDLE; it is not cleared on handshake.

Optional Feature:
Macro TRINITY_BREED_STATS_EN.
- Defined: adds outputs stat_children [31:0] and stat_mutations [31:0].
  - stat_children increments on each out handshake.
  - stat_mutations adds mut_count on each out handshake.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
  - Adds input stat_clear, which zeroes both counters synchronously. If stat_clear coincides with a handshake, the clear wins.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. N_TRITS = 32, LANES = 4, mut_thresh = 0, parent_a and parent_b both 64'h9999_9999_9999_9999 -> child equals the parent, mut_count = 0, out_valid rises 9 edges after accept.
2. mut_thresh = 0, parent_a all 10 (+1), parent_b all 00 (-1), uniform mode -> each child trit is 10 when the model's x[8] = 1 and 00 otherwise; matches a bit-exact reference model from LFSR_SEED.
3. parent_a = parent_b = all 11, mut_thresh = 0 -> child = 64'h5555_5555_5555_5555 (all 01), mut_count = 0.
4. XOVER_MODE = 1, seed_load with seed = 32'h0000_0005 in the accept cycle, mut_thresh = 0 -> cut = 5; trits 0-4 come from A and 5-31 from B. Repeat with seed = 0 -> LFSR_SEED is used and cut = 1.
5. mut_thresh = 255, out_ready held low 6 cycles in DONE -> child and mut_count are stable, in_ready = 0, busy = 1; mut_count matches the model (at least 30 for the default seed); handshake then returns to IDLE.
6. Assert reset at beat 3 of BREED -> out_valid, busy and mut_count go to 0 immediately, in_ready = 1; the next job reproduces the result of a fresh post-reset run.

Source files
------------

// File: rtl/trinity_genome_breeder.sv
// Ternary genetic operator: crossover, mutation and canonicalisation of two parent genomes.
// Optional macro TRINITY_BREED_STATS_EN adds child/mutation statistics counters.
module trinity_genome_breeder #(
  parameter int          N_TRITS    = 32,
  parameter int          LANES      = 4,
  parameter int          XOVER_MODE = 0,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*N_TRITS-1:0]         parent_a,
  input  logic [2*N_TRITS-1:0]         parent_b,
  input  logic [7:0]                   mut_thresh,
  input  logic                         seed_load,
  input  logic [31:0]                  seed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*N_TRITS-1:0]         child,
  output logic [$clog2(N_TRITS+1)-1:0] mut_count,
`ifdef TRINITY_BREED_STATS_EN
  input  logic                         stat_clear,
  output logic [31:0]                  stat_children,
  output logic [31:0]                  stat_mutations,
`endif
  output logic                         busy
);

  localparam int NB  = N_TRITS / LANES;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW  = $clog2(N_TRITS);
  localparam int MCW = $clog2(N_TRITS + 1);
  localparam int LCW = $clog2(LANES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BREED, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          lfsr, lfsr_load;
  logic [2*N_TRITS-1:0] pa, pb, child_d;
  logic [7:0]           thresh;
  logic [CW-1:0]        cut;
  logic [BW-1:0]        beat;
  logic [LCW-1:0]       mut_add;
  logic [10:0]          x;
  logic                 pick_a;
  logic [1:0]           t;
  int                   j;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign lfsr_load = (seed == 32'd0) ? LFSR_SEED : seed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_BREED;
      S_BREED: if (beat == BW'(NB - 1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane k of the current beat sees the LFSR rotated right by 7*k.
  always_comb begin
    child_d = child;
    mut_add = '0;
    x       = '0;
    pick_a  = 1'b0;
    t       = 2'b01;
    j       = 0;
    for (int k = 0; k < LANES; k++) begin
      x = 11'({lfsr, lfsr} >> ((7 * k) % 32));
      j = int'(beat) * LANES + k;
      if (XOVER_MODE == 1) pick_a = (j < int'(cut));
      else                 pick_a = x[8];
      t = pick_a ? pa[2*j +: 2] : pb[2*j +: 2];
      if (x[7:0] < thresh) begin
        t       = x[10:9];
        mut_add = mut_add + LCW'(1);
      end
      if (t == 2'b11) t = 2'b01;
      child_d[2*j +: 2] = t;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr      <= LFSR_SEED;
      pa        <= '0;
      pb        <= '0;
      thresh    <= '0;
      cut       <= '0;
      beat      <= '0;
      child     <= '0;
      mut_count <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (seed_load) lfsr <= lfsr_load;
          if (in_valid) begin
            pa        <= parent_a;
            pb        <= parent_b;
            thresh    <= mut_thresh;
            cut       <= seed_load ? lfsr_load[CW-1:0] : lfsr[CW-1:0];
            beat      <= '0;
            mut_count <= '0;
          end
        end
        S_BREED: begin
          lfsr      <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
          child     <= child_d;
          mut_count <= mut_count + MCW'(mut_add);
          beat      <= beat + BW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef TRINITY_BREED_STATS_EN
  logic        done_hs;
  logic [32:0] mut_sum;

  assign done_hs = (state_q == S_DONE) && out_ready;
  assign mut_sum = {1'b0, stat_mutations} + 33'(mut_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_children  <= '0;
      stat_mutations <= '0;
    end else if (stat_clear) begin
      stat_children  <= '0;
      stat_mutations <= '0;
    end else if (done_hs) begin
      if (stat_children != 32'hFFFF_FFFF) stat_children <= stat_children + 32'd1;
      stat_mutations <= mut_sum[32] ? 32'hFFFF_FFFF : mut_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_trinity_genome_breeder.sv
// Bench for trinity_genome_breeder: uniform and single-point instances share one stimulus
// stream and are compared against a trit-level reference model.
module tb_trinity_genome_breeder;

  localparam logic [31:0] SEED = 32'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] pa = '0, pb = '0;
  logic [7:0]  th = '0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        out_ready = 1'b0;

  logic        ir_u, ov_u, busy_u, ir_s, ov_s, busy_s;
  logic [63:0] child_u, child_s;
  logic [5:0]  mc_u, mc_s;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_lfsr;
  logic [63:0] e_u, e_s;
  logic [5:0]  e_cnt;
  logic [63:0] r_u, r_s;
  logic [5:0]  r_c;
  logic [63:0] ra, rb;
  logic [7:0]  rth;

  always #5 clk = ~clk;

  trinity_genome_breeder #(.N_TRITS(32), .LANES(4), .XOVER_MODE(0), .LFSR_SEED(SEED)) u_uni (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_u),
    .parent_a(pa), .parent_b(pb), .mut_thresh(th), .seed_load(seed_load), .seed(seed),
    .out_valid(ov_u), .out_ready(out_ready), .child(child_u), .mut_count(mc_u), .busy(busy_u));

  trinity_genome_breeder #(.N_TRITS(32), .LANES(4), .XOVER_MODE(1), .LFSR_SEED(SEED)) u_sp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_s),
    .parent_a(pa), .parent_b(pb), .mut_thresh(th), .seed_load(seed_load), .seed(seed),
    .out_valid(ov_s), .out_ready(out_ready), .child(child_s), .mut_count(mc_s), .busy(busy_s));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
  endfunction

  function automatic logic [1:0] canon(input logic [1:0] v);
    return (v == 2'b11) ? 2'b01 : v;
  endfunction

  // Trit j is bred from the LFSR state after j/4 advances, seen rotated right by 7*(j%4).
  task automatic model_job(input logic [63:0] a, input logic [63:0] b, input logic [7:0] mt,
                           input logic sl, input logic [31:0] sd);
    logic [31:0] r, xr;
    logic [4:0]  cut;
    logic [1:0]  tu, ts, mv;
    int          cnt;
    if (sl) m_lfsr = (sd == 32'd0) ? SEED : sd;
    cut = m_lfsr[4:0];
    r   = m_lfsr;
    cnt = 0;
    for (int j = 0; j < 32; j++) begin
      if (j > 0 && j % 4 == 0) r = lfsr_step(r);
      xr = (r >> ((7 * (j % 4)) % 32)) | (r << (32 - ((7 * (j % 4)) % 32)));
      tu = xr[8] ? a[2*j +: 2] : b[2*j +: 2];
      ts = (j < int'(cut)) ? a[2*j +: 2] : b[2*j +: 2];
      if (xr[7:0] < mt) begin
        mv = xr[10:9];
        tu = mv;
        ts = mv;
        cnt++;
      end
      e_u[2*j +: 2] = canon(tu);
      e_s[2*j +: 2] = canon(ts);
    end
    m_lfsr = lfsr_step(r);
    e_cnt  = 6'(cnt);
  endtask

  task automatic run_job(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [7:0] mt, input logic sl, input logic [31:0] sd, input int hold);
    int edges;
    logic got;
    model_job(a, b, mt, sl, sd);
    pa = a; pb = b; th = mt; seed_load = sl; seed = sd;
    in_valid = 1'b1;
    out_ready = 1'b0;
    chk({tag, " in_ready"}, 64'({ir_u, ir_s}), 64'b11);
    edges = 0;
    got = 1'b0;
    while (!got && edges < 30) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        in_valid = 1'b0;
        seed_load = 1'b0;
        chk({tag, " busy_after_accept"}, 64'({busy_u, busy_s, ir_u, ir_s}), 64'b1100);
      end
      if (ov_u && ov_s) got = 1'b1;
    end
    chk({tag, " latency_edges"}, 64'(edges), 64'd9);
    chk({tag, " child_uni"}, child_u, e_u);
    chk({tag, " child_sp"}, child_s, e_s);
    chk({tag, " mut_count"}, 64'({mc_u, mc_s}), 64'({e_cnt, e_cnt}));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " hold_child"}, child_u ^ child_s, e_u ^ e_s);
      chk({tag, " hold_flags"}, 64'({ov_u, busy_u, ir_u, mc_u}), 64'({3'b110, e_cnt}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " post_hs_flags"}, 64'({ov_u, ov_s, busy_u, busy_s, ir_u, ir_s}), 64'b000011);
    chk({tag, " post_hs_child"}, child_u, e_u);
  endtask

  initial begin
    m_lfsr = SEED;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 64'({ov_u, busy_u, ir_u, ov_s, busy_s, ir_s}), 64'b001001);
    chk("reset_child", child_u | child_s, 64'd0);
    chk("reset_mc", 64'({mc_u, mc_s}), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    rth = 8'($urandom_range(40, 200));
    run_job("first", ra, rb, rth, 1'b0, 32'd0, 0);
    r_u = e_u; r_s = e_s; r_c = e_cnt;

    run_job("t1_same", 64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999, 8'd0, 1'b0, 32'd0, 2);
    chk("t1_equals_parent", child_u, 64'h9999_9999_9999_9999);

    run_job("t2_uniform", 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 8'd0, 1'b0, 32'd0, 0);

    run_job("t3_illegal", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0, 1'b0, 32'd0, 0);
    chk("t3_all_zero", child_u & child_s, 64'h5555_5555_5555_5555);

    run_job("t4_cut5", 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 8'd0, 1'b1, 32'h0000_0005, 0);
    chk("t4_cut5_direct", child_s, 64'h0000_0000_0000_02AA);
    run_job("t4_cut_zero_seed", 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 8'd0, 1'b1, 32'd0, 0);
    chk("t4_cut1_direct", child_s, 64'h0000_0000_0000_0002);

    run_job("t5_full_mut", {$urandom, $urandom}, {$urandom, $urandom}, 8'd255, 1'b0, 32'd0, 6);

    for (int n = 0; n < 4; n++) begin
      run_job("rand", {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
              1'($urandom_range(0, 1)), $urandom, n % 2);
    end

    // Abort a job at beat 3, then replay the very first job from the reset seed.
    pa = {$urandom, $urandom}; pb = {$urandom, $urandom}; th = 8'd255;
    in_valid = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("t6_reset_flags", 64'({ov_u, busy_u, ir_u, ov_s, busy_s, ir_s}), 64'b001001);
    chk("t6_reset_mc", 64'({mc_u, mc_s}), 64'd0);
    chk("t6_reset_child", child_u | child_s, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_lfsr = SEED;
    @(posedge clk);
    #1;
    run_job("t6_replay", ra, rb, rth, 1'b0, 32'd0, 0);
    chk("t6_replay_uni", child_u, r_u);
    chk("t6_replay_sp", child_s, r_s);
    chk("t6_replay_mc", 64'(mc_u), 64'(r_c));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
